// File: rtl/nn_layer_pkg.sv
// Shared types and arithmetic helpers for the sequential fully-connected layer.
package nn_layer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFinish,
    StBias,
    StOut
  } state_e;

  // Working width for the bias/shift/saturate path; ACC_W and BIAS_W must stay below it.
  localparam int unsigned SatW = 128;

  // Index width, kept at least one bit so a single-input layer still has an address port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Adds bias, arithmetic-shifts by frac, clamps to a signed out_w range, optional ReLU.
  // The result is sign-correct in its low out_w bits.
  function automatic logic signed [SatW-1:0] sat_shift(input logic signed [SatW-1:0] acc,
                                                       input logic signed [SatW-1:0] bias,
                                                       input int unsigned            frac,
                                                       input int unsigned            out_w,
                                                       input logic                   relu);
    logic signed [SatW-1:0] s;
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    s  = (acc + bias) >>> frac;
    hi = {{(SatW-1){1'b0}}, 1'b1};
    hi = (hi <<< (out_w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) begin
      s = hi;
    end else if (s < lo) begin
      s = lo;
    end
    if (relu && s[SatW-1]) begin
      s = '0;
    end
    return s;
  endfunction

endpackage

// File: rtl/nn_layer_seq_mac_lane.sv
// One neuron lane: multiply-accumulate of the streamed input, then bias/rescale/saturate.
module mac_lane
  import nn_layer_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned WEIGHT_W  = 16,
  parameter int unsigned BIAS_W    = 32,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned OUT_W     = 24,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   x,
  input  logic signed [WEIGHT_W-1:0] w,
  input  logic signed [BIAS_W-1:0]   bias,
  input  logic                       relu,
  input  logic                       fin,
  output logic signed [OUT_W-1:0]    y
);

  localparam int unsigned ProdW = DATA_W + WEIGHT_W;

  logic signed [ProdW-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [SatW-1:0]  sat;
  logic signed [OUT_W-1:0] y_q, y_d;

  // Operands are sign-extended to the product width, so the low ProdW bits are the exact
  // signed product.
  assign prod = {{WEIGHT_W{x[DATA_W-1]}}, x} * {{DATA_W{w[WEIGHT_W-1]}}, w};

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W-ProdW){prod[ProdW-1]}}, prod};
    end
    sat = sat_shift({{(SatW-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                    {{(SatW-BIAS_W){bias[BIAS_W-1]}}, bias},
                    FRAC_BITS, OUT_W, relu);
    y_d = sat[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      if (fin) begin
        y_q <= y_d;
      end
    end
  end

  assign y = y_q;

endmodule

// File: rtl/nn_layer_seq.sv
// Sequential fully-connected layer: shared input stream and index counter, NUM_NEURONS lanes.
module nn_layer_seq
  import nn_layer_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WEIGHT_W    = 16,
  parameter int unsigned BIAS_W      = 32,
  parameter int unsigned ACC_W       = 48,
  parameter int unsigned OUT_W       = 24,
  parameter int unsigned FRAC_BITS   = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              relu_en,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  output logic [idx_width(NUM_INPUTS)-1:0]  w_addr,
  input  logic [NUM_NEURONS*WEIGHT_W-1:0]   w_data,
  input  logic [NUM_NEURONS*BIAS_W-1:0]     bias,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_NEURONS*OUT_W-1:0]      out_data,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned IDX_W = idx_width(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_INPUTS - 1);

  if (NUM_INPUTS < 1) begin : g_bad_num_inputs
    $error("NUM_INPUTS must be at least 1");
  end
  if (ACC_W < DATA_W + WEIGHT_W + $clog2(NUM_INPUTS) + 1) begin : g_bad_acc_w
    $error("ACC_W too narrow for worst-case accumulation");
  end
  if (ACC_W >= SatW || BIAS_W >= SatW) begin : g_bad_sat_w
    $error("ACC_W and BIAS_W must be narrower than the saturation working width");
  end

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  x_q;
  logic               x_vld_q;
  logic               relu_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               lane_clr;
  logic               lane_fin;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      x_q         <= '0;
      x_vld_q     <= 1'b0;
      relu_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      x_vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            relu_q     <= relu_en;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StAccum;
          end
        end
        StAccum: begin
          // in_ready_q is high throughout this state, so in_valid alone is the handshake.
          if (in_valid) begin
            x_q     <= in_data;
            x_vld_q <= 1'b1;
            if (idx_q == LastIdx) begin
              idx_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= StFinish;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StFinish: begin
          state_q <= StBias;
        end
        StBias: begin
          out_valid_q <= 1'b1;
          state_q     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign lane_clr = (state_q == StIdle) && start;
  assign lane_fin = (state_q == StBias);

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
    logic signed [OUT_W-1:0] y;

    mac_lane #(
      .DATA_W    (DATA_W),
      .WEIGHT_W  (WEIGHT_W),
      .BIAS_W    (BIAS_W),
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .clr  (lane_clr),
      .en   (x_vld_q),
      .x    (x_q),
      .w    (w_data[n*WEIGHT_W +: WEIGHT_W]),
      .bias (bias[n*BIAS_W +: BIAS_W]),
      .relu (relu_q),
      .fin  (lane_fin),
      .y    (y)
    );

    assign out_data[n*OUT_W +: OUT_W] = y;
  end

  assign in_ready  = in_ready_q;
  assign w_addr    = idx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = out_valid_q && out_ready;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench: two layer instances (FRAC_BITS 0 and 4) share stimulus and a weight ROM.
module tb_nn_layer_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        relu_en;
  logic        in_valid;
  logic [15:0] in_data;
  logic [63:0] bias;
  logic        out_ready;
  logic [31:0] w_data = '0;

  logic        in_ready, out_valid, busy, done;
  logic [1:0]  w_addr;
  logic [15:0] out_data;
  logic        in_ready4, out_valid4, busy4, done4;
  logic [1:0]  w_addr4;
  logic [15:0] out_data4;

  logic [31:0] rom [4];
  int          xv [4];
  int          w0 [4];
  int          w1 [4];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) w_data <= rom[w_addr];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  nn_layer_seq #(
    .NUM_NEURONS (2), .NUM_INPUTS (4), .DATA_W (16), .WEIGHT_W (16),
    .BIAS_W (32), .ACC_W (48), .OUT_W (8), .FRAC_BITS (0)
  ) dut (
    .clk (clk), .rstn (rstn), .start (start), .relu_en (relu_en),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .w_addr (w_addr), .w_data (w_data), .bias (bias),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .busy (busy), .done (done)
  );

  nn_layer_seq #(
    .NUM_NEURONS (2), .NUM_INPUTS (4), .DATA_W (16), .WEIGHT_W (16),
    .BIAS_W (32), .ACC_W (48), .OUT_W (8), .FRAC_BITS (4)
  ) dut4 (
    .clk (clk), .rstn (rstn), .start (start), .relu_en (relu_en),
    .in_valid (in_valid), .in_ready (in_ready4), .in_data (in_data),
    .w_addr (w_addr4), .w_data (w_data), .bias (bias),
    .out_valid (out_valid4), .out_ready (out_ready), .out_data (out_data4),
    .busy (busy4), .done (done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] pk(input int l0, input int l1);
    return {l1[7:0], l0[7:0]};
  endfunction

  task automatic load(input int b0, input int b1);
    for (int i = 0; i < 4; i++) rom[i] = {w1[i][15:0], w0[i][15:0]};
    bias = {b1[31:0], b0[31:0]};
  endtask

  task automatic begin_pass(input string tag, input logic relu);
    relu_en = relu;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    relu_en = 1'b0;
    chk1({tag, "_busy"}, busy, 1'b1);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic send(input string tag, input int v);
    int waited;
    in_valid = 1'b1;
    in_data  = v[15:0];
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) chk1({tag, "_in_ready_timeout"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic feed(input string tag, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        // Mid-pass start with relu_en set must neither restart nor change the activation.
        if (i == 2) begin
          start   = 1'b1;
          relu_en = 1'b1;
        end
        tick();
        start   = 1'b0;
        relu_en = 1'b0;
      end
      send(tag, xv[i]);
    end
  endtask

  task automatic finish_pass(input string tag, input logic [15:0] e0, input logic [15:0] e4,
                             input int stall);
    int d0;
    d0 = done_cnt;
    chk1({tag, "_in_ready_drop"}, in_ready, 1'b0);
    tick();
    chk1({tag, "_valid_c2"}, out_valid, 1'b0);
    tick();
    chk1({tag, "_valid_c3"}, out_valid, 1'b1);
    chk16({tag, "_data"}, out_data, e0);
    chk16({tag, "_data_f4"}, out_data4, e4);
    for (int c = 0; c < stall; c++) begin
      tick();
      chk1({tag, "_stall_valid"}, out_valid, 1'b1);
      chk16({tag, "_stall_data"}, out_data, e0);
      chk1({tag, "_stall_done"}, done, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk1({tag, "_done"}, done, 1'b1);
    tick();
    out_ready = 1'b0;
    chk1({tag, "_valid_fall"}, out_valid, 1'b0);
    chk1({tag, "_idle"}, busy, 1'b0);
    chk16({tag, "_retain"}, out_data, e0);
    chk16({tag, "_done_count"}, 16'(done_cnt - d0), 16'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    relu_en   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bias      = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    #3;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_data", out_data, 16'h0000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk16("rst_w_addr", {14'b0, w_addr}, 16'h0000);
    tick();
    rstn = 1'b1;
    tick();

    // Basic linear pass: lanes 1+2+3+4=10 and -10+5=-5; with FRAC_BITS 4: 0 and -1.
    xv = '{1, 2, 3, 4}; w0 = '{1, 1, 1, 1}; w1 = '{-1, -1, -1, -1};
    load(0, 5);
    begin_pass("basic", 1'b0);
    feed("basic", 1'b0);
    finish_pass("basic", pk(10, -5), pk(0, -1), 0);

    // in_valid while idle is ignored.
    in_valid = 1'b1;
    tick();
    tick();
    chk1("idle_in_ready", in_ready, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    in_valid = 1'b0;

    // ReLU clips the negative lane.
    begin_pass("relu", 1'b1);
    feed("relu", 1'b0);
    finish_pass("relu", pk(10, 0), pk(0, 0), 0);

    // Saturation: +-40000 clamps to +127 / -128 (and +-2500 after the 4-bit shift).
    xv = '{100, 100, 100, 100}; w0 = '{100, 100, 100, 100}; w1 = '{-100, -100, -100, -100};
    load(0, 0);
    begin_pass("sat", 1'b0);
    feed("sat", 1'b0);
    finish_pass("sat", pk(127, -128), pk(127, -128), 0);

    // Scaling: 16 and -16 shifted right by 4 give 1 and -1 (floor).
    xv = '{16, 0, 0, 0}; w0 = '{1, 0, 0, 0}; w1 = '{-1, 0, 0, 0};
    load(0, 0);
    begin_pass("scale", 1'b0);
    feed("scale", 1'b0);
    finish_pass("scale", pk(16, -16), pk(1, -1), 0);

    // Input gaps, a start pulse mid-pass and five cycles of output backpressure.
    xv = '{1, 2, 3, 4}; w0 = '{1, 1, 1, 1}; w1 = '{-1, -1, -1, -1};
    load(0, 5);
    begin_pass("bp", 1'b0);
    feed("bp", 1'b1);
    finish_pass("bp", pk(10, -5), pk(0, -1), 5);

    // Reset after two handshakes discards the partial pass.
    begin_pass("rstmid", 1'b0);
    send("rstmid", xv[0]);
    send("rstmid", xv[1]);
    chk16("rstmid_w_addr", {14'b0, w_addr}, 16'h0002);
    rstn = 1'b0;
    #1;
    chk1("rstmid_in_ready", in_ready, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_out_valid", out_valid, 1'b0);
    chk16("rstmid_out_data", out_data, 16'h0000);
    chk16("rstmid_w_addr0", {14'b0, w_addr}, 16'h0000);
    chk1("rstmid_done", done, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    begin_pass("fresh", 1'b0);
    feed("fresh", 1'b0);
    finish_pass("fresh", pk(10, -5), pk(0, -1), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
